// File: rtl/neuron_tdm_scheduler.sv
// Purpose: time-division scheduler that shares one neuron update datapath across N_NEURONS (v,u) contexts.
// Latency: tick->dp_start 1 cycle; each neuron takes 1 (ISSUE) + L (datapath) + 1 (COMMIT) cycles; spike->ev_valid 1 cycle.
// Backpressure: the datapath has none (start/done); spike events are valid/ready, and a push into a full FIFO without a pop is dropped (ev_drop).
// Optional feature: NEURON_SCHED_REFRACT_EN adds per-neuron refractory skipping (REFRACT_STEPS sweeps after a spike).
module neuron_tdm_scheduler #(
    parameter int N_NEURONS     = 8,
    parameter int IDX_W         = 3,
    parameter int DW            = 32,
    parameter int STEP_DIV      = 1024,
    parameter int FIFO_DEPTH    = 4
`ifdef NEURON_SCHED_REFRACT_EN
    ,
    parameter int REFRACT_STEPS = 2
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr_flags,
    output logic             dp_start,
    output logic [IDX_W-1:0] dp_idx,
    output logic [DW-1:0]    dp_v_in,
    output logic [DW-1:0]    dp_u_in,
    input  logic             dp_done,
    input  logic [DW-1:0]    dp_v_out,
    input  logic [DW-1:0]    dp_u_out,
    input  logic             dp_spike,
    output logic             ev_valid,
    output logic [IDX_W-1:0] ev_idx,
    input  logic             ev_ready,
    output logic             step_done,
    output logic [15:0]      step_cnt,
    output logic             busy,
    output logic             overrun,
    output logic             ev_drop
);

    localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int FA_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FP_W  = FA_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);
    localparam logic [CNT_W-1:0] TICK_AT  = CNT_W'(STEP_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_tick_cnt;
    logic             w_tick;
    logic [IDX_W-1:0] r_idx;
    logic             w_last;
    logic             w_skip;
    logic             w_commit;
    logic [DW-1:0]    r_res_v;
    logic [DW-1:0]    r_res_u;
    logic             r_res_spk;
    logic [15:0]      r_step_cnt;
    logic             r_overrun;
    logic             r_ev_drop;
    logic [DW-1:0]    r_v [N_NEURONS];
    logic [DW-1:0]    r_u [N_NEURONS];

    // spike event FIFO (pointers carry one extra wrap bit to tell full from empty)
    logic [IDX_W-1:0] r_fifo [FIFO_DEPTH];
    logic [FP_W-1:0]  r_wr_ptr;
    logic [FP_W-1:0]  r_rd_ptr;
    logic [FP_W-1:0]  w_fifo_cnt;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push_req;
    logic             w_push;
    logic             w_drop;

    // Step tick divider: counts 0..STEP_DIV-1 while en is high, frozen otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (en) begin
            if (r_tick_cnt == TICK_AT) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + CNT_W'(1);
            end
        end
    end

    assign w_tick = en && (r_tick_cnt == TICK_AT);
    assign w_last = (r_idx == LAST_IDX);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and per-cycle strobes; a skipped neuron retires directly from ISSUE.
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        dp_start    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_tick) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_skip) begin
                    w_commit    = 1'b1;
                    w_state_nxt = w_last ? ST_IDLE : ST_ISSUE;
                end else begin
                    dp_start    = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dp_done) begin
                    w_state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = w_last ? ST_IDLE : ST_ISSUE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign step_done = w_commit && w_last;
    assign busy      = (r_state != ST_IDLE);

    // Sweep index, datapath result capture and completed-sweep counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_res_v    <= '0;
            r_res_u    <= '0;
            r_res_spk  <= 1'b0;
            r_step_cnt <= '0;
        end else begin
            if ((r_state == ST_IDLE) && w_tick) begin
                r_idx <= '0;
            end else if (w_commit && !w_last) begin
                r_idx <= r_idx + IDX_W'(1);
            end
            // dp_done is only meaningful while an update is outstanding
            if ((r_state == ST_WAIT) && dp_done) begin
                r_res_v   <= dp_v_out;
                r_res_u   <= dp_u_out;
                r_res_spk <= dp_spike;
            end
            if (step_done) begin
                r_step_cnt <= r_step_cnt + 16'd1;
            end
        end
    end

    // Neuron state storage: written back only in COMMIT, so operands stay stable during WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                r_v[i] <= '0;
                r_u[i] <= '0;
            end
        end else if (r_state == ST_COMMIT) begin
            r_v[r_idx] <= r_res_v;
            r_u[r_idx] <= r_res_u;
        end
    end

    assign dp_idx  = r_idx;
    assign dp_v_in = r_v[r_idx];
    assign dp_u_in = r_u[r_idx];

`ifdef NEURON_SCHED_REFRACT_EN
    localparam int RC_W = (REFRACT_STEPS > 0) ? $clog2(REFRACT_STEPS + 1) : 1;

    logic [RC_W-1:0] r_refr [N_NEURONS];

    assign w_skip = (r_refr[r_idx] != '0);

    // Refractory counters: loaded when a neuron fires, decremented each sweep it is passed over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                r_refr[i] <= '0;
            end
        end else if ((r_state == ST_COMMIT) && r_res_spk) begin
            r_refr[r_idx] <= RC_W'(REFRACT_STEPS);
        end else if ((r_state == ST_ISSUE) && w_skip) begin
            r_refr[r_idx] <= r_refr[r_idx] - RC_W'(1);
        end
    end
`else
    assign w_skip = 1'b0;
`endif

    assign w_fifo_cnt = r_wr_ptr - r_rd_ptr;
    assign w_full     = (w_fifo_cnt == FP_W'(FIFO_DEPTH));
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_pop      = !w_empty && ev_ready;
    assign w_push_req = (r_state == ST_COMMIT) && r_res_spk;
    // a pop in the same cycle frees the slot, so a push onto a full FIFO still lands
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    assign ev_valid = !w_empty;
    assign ev_idx   = r_fifo[r_rd_ptr[FA_W-1:0]];

    // FIFO pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + FP_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + FP_W'(1);
            end
        end
    end

    // FIFO storage, cleared so ev_idx reads 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
        end else if (w_push) begin
            r_fifo[r_wr_ptr[FA_W-1:0]] <= r_idx;
        end
    end

    // Sticky status flags: a new event in the same cycle as clr_flags keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
            r_ev_drop <= 1'b0;
        end else begin
            if (w_tick && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end else if (clr_flags) begin
                r_overrun <= 1'b0;
            end
            if (w_drop) begin
                r_ev_drop <= 1'b1;
            end else if (clr_flags) begin
                r_ev_drop <= 1'b0;
            end
        end
    end

    assign step_cnt = r_step_cnt;
    assign overrun  = r_overrun;
    assign ev_drop  = r_ev_drop;

endmodule

// File: tb/tb_neuron_tdm_scheduler.sv
// Directed bench: 4 neurons, 64-cycle step, datapath model returning v+1 / u+2 after a programmable latency.
// Timing: all DUT outputs sampled 1 time unit after the rising edge; inputs driven with blocking assignments.
// Backpressure: ev_ready is held low or high per test to fill, overflow and drain the spike FIFO.
module tb_neuron_tdm_scheduler;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int DW = 32;
    localparam int SD = 64;
    localparam int FD = 4;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          en        = 1'b0;
    logic          clr_flags = 1'b0;
    logic          dp_start;
    logic [IW-1:0] dp_idx;
    logic [DW-1:0] dp_v_in;
    logic [DW-1:0] dp_u_in;
    logic          dp_done   = 1'b0;
    logic [DW-1:0] dp_v_out  = '0;
    logic [DW-1:0] dp_u_out  = '0;
    logic          dp_spike  = 1'b0;
    logic          ev_valid;
    logic [IW-1:0] ev_idx;
    logic          ev_ready  = 1'b0;
    logic          step_done;
    logic [15:0]   step_cnt;
    logic          busy;
    logic          overrun;
    logic          ev_drop;

    int            n_checks = 0;
    int            n_errors = 0;
    int            cur_cyc  = 0;
    int            dp_lat   = 3;
    logic [N-1:0]  spike_mask = '0;

    // per-sweep record filled by watch_sweep
    int            st_n;
    int            st_cyc [8];
    logic [IW-1:0] st_idx [8];
    logic [DW-1:0] st_v   [8];
    logic [DW-1:0] st_u   [8];
    int            sd_cyc;
    int            hits;
    logic [DW-1:0] hit_v;

    neuron_tdm_scheduler #(
        .N_NEURONS  (N),
        .IDX_W      (IW),
        .DW         (DW),
        .STEP_DIV   (SD),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .clr_flags (clr_flags),
        .dp_start  (dp_start),
        .dp_idx    (dp_idx),
        .dp_v_in   (dp_v_in),
        .dp_u_in   (dp_u_in),
        .dp_done   (dp_done),
        .dp_v_out  (dp_v_out),
        .dp_u_out  (dp_u_out),
        .dp_spike  (dp_spike),
        .ev_valid  (ev_valid),
        .ev_idx    (ev_idx),
        .ev_ready  (ev_ready),
        .step_done (step_done),
        .step_cnt  (step_cnt),
        .busy      (busy),
        .overrun   (overrun),
        .ev_drop   (ev_drop)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick1();
        @(posedge clk);
        #1;
        cur_cyc++;
    endtask

    task automatic reset_assert();
        @(negedge clk);
        rst_n = 1'b0;
        en    = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic reset_release();
        rst_n   = 1'b1;
        en      = 1'b1;
        cur_cyc = 0;
    endtask

    // Follows one sweep until step_done, recording every dp_start.
    task automatic watch_sweep(input int budget);
        int got_done;
        got_done = 0;
        st_n     = 0;
        sd_cyc   = -1;
        for (int t = 0; t < budget && got_done == 0; t++) begin
            tick1();
            if (dp_start && st_n < 8) begin
                st_cyc[st_n] = cur_cyc;
                st_idx[st_n] = dp_idx;
                st_v[st_n]   = dp_v_in;
                st_u[st_n]   = dp_u_in;
                st_n++;
            end
            if (step_done) begin
                got_done = 1;
                sd_cyc   = cur_cyc;
            end
        end
        if (got_done == 0) begin
            check_val("sweep_timeout", 64'd0, 64'd1);
        end
    endtask

    // Datapath model: latches operands at dp_start, answers dp_lat cycles later with v+1, u+2.
    initial begin : dp_model
        int            lat;
        logic [IW-1:0] ri;
        logic [DW-1:0] rv;
        logic [DW-1:0] ru;
        forever begin
            @(negedge clk);
            if (dp_start) begin
                lat = dp_lat;
                ri  = dp_idx;
                rv  = dp_v_in;
                ru  = dp_u_in;
                repeat (lat) @(posedge clk);
                #1;
                dp_done  = 1'b1;
                dp_v_out = rv + 32'd1;
                dp_u_out = ru + 32'd2;
                dp_spike = spike_mask[ri];
                @(posedge clk);
                #1;
                dp_done  = 1'b0;
                dp_spike = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : main
        // ---- reset values and basic sweep timing ----
        reset_assert();
        check_val("rst_ctrl", {dp_start, busy, ev_valid, step_done, overrun, ev_drop}, 64'd0);
        check_val("rst_step_cnt", step_cnt, 64'd0);
        check_val("rst_operands", {dp_idx, dp_v_in, dp_u_in, ev_idx}, 64'd0);
        reset_release();
        watch_sweep(200);
        check_val("a1_nstart", st_n, 64'd4);
        for (int k = 0; k < 4; k++) begin
            check_val($sformatf("a1_cyc%0d", k), st_cyc[k], 64'(SD + 5 * k));
            check_val($sformatf("a1_idx%0d", k), st_idx[k], 64'(k));
            check_val($sformatf("a1_v%0d", k), st_v[k], 64'd0);
        end
        check_val("a1_done_cyc", sd_cyc, 64'd83);
        check_val("a1_busy_at_done", busy, 64'd1);
        tick1();
        check_val("a1_busy_after", busy, 64'd0);
        check_val("a1_step_cnt", step_cnt, 64'd1);
        watch_sweep(200);
        check_val("a2_start_cyc", st_cyc[0], 64'd128);
        for (int k = 0; k < 4; k++) begin
            check_val($sformatf("a2_v%0d", k), st_v[k], 64'd1);
            check_val($sformatf("a2_u%0d", k), st_u[k], 64'd2);
        end
        tick1();
        check_val("a2_step_cnt", step_cnt, 64'd2);

        // ---- spike ordering with ready held low ----
        reset_assert();
        spike_mask = 4'b1010;
        ev_ready   = 1'b0;
        reset_release();
        watch_sweep(200);
        spike_mask = 4'b0000;
        tick1();
        check_val("b_ev_valid", ev_valid, 64'd1);
        check_val("b_ev_head0", ev_idx, 64'd1);
        ev_ready = 1'b1;
        tick1();
        check_val("b_ev_head1", {ev_valid, ev_idx}, {62'd0, 1'b1, 2'd3});
        tick1();
        check_val("b_ev_empty", ev_valid, 64'd0);
        ev_ready = 1'b0;

        // ---- overflow: 4 spikes fill the FIFO, a 5th is dropped ----
        reset_assert();
        spike_mask = 4'b0011;
        reset_release();
        watch_sweep(200);
        spike_mask = 4'b1100;
        watch_sweep(200);
        spike_mask = 4'b0000;
        tick1();
        check_val("b_full_nodrop", ev_drop, 64'd0);
        check_val("b_full_head", {ev_valid, ev_idx}, {62'd0, 1'b1, 2'd0});
        watch_sweep(200);
        spike_mask = 4'b0001;
        watch_sweep(200);
        spike_mask = 4'b0000;
        tick1();
        check_val("b_drop_set", ev_drop, 64'd1);
        clr_flags = 1'b1;
        tick1();
        clr_flags = 1'b0;
        check_val("b_drop_clr", ev_drop, 64'd0);
        ev_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check_val($sformatf("b_drain%0d", k), {ev_valid, ev_idx}, {61'd0, 1'b1, 2'(k)});
            tick1();
        end
        check_val("b_drain_empty", ev_valid, 64'd0);
        ev_ready = 1'b0;

        // ---- overrun: 4*(15+2)=68 cycles per sweep exceeds the 64-cycle step ----
        reset_assert();
        dp_lat = 15;
        reset_release();
        watch_sweep(200);
        check_val("c1_nstart", st_n, 64'd4);
        check_val("c1_start", st_cyc[0], 64'd64);
        check_val("c1_start3", st_cyc[3], 64'd115);
        check_val("c1_done_cyc", sd_cyc, 64'd131);
        tick1();
        check_val("c1_overrun", overrun, 64'd1);
        check_val("c1_step_cnt", step_cnt, 64'd1);
        check_val("c1_busy", busy, 64'd0);
        clr_flags = 1'b1;
        tick1();
        clr_flags = 1'b0;
        check_val("c_overrun_clr", overrun, 64'd0);
        watch_sweep(300);
        check_val("c2_start", st_cyc[0], 64'd192);
        check_val("c2_nstart", st_n, 64'd4);
        tick1();
        check_val("c2_step_cnt", step_cnt, 64'd2);
        check_val("c2_overrun", overrun, 64'd1);
        dp_lat = 3;

        // ---- reset while WAIT, model's late dp_done arrives after release ----
        reset_assert();
        reset_release();
        for (int t = 0; t < 100 && !dp_start; t++) begin
            tick1();
        end
        check_val("d_first_start", cur_cyc, 64'd64);
        tick1();
        rst_n = 1'b0;
        #1;
        check_val("d_busy_in_rst", busy, 64'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        cur_cyc = 0;
        repeat (4) tick1();
        check_val("d_idle_after_stray", {busy, dp_start, step_done}, 64'd0);
        check_val("d_step_cnt", step_cnt, 64'd0);
        watch_sweep(200);
        check_val("d_start", st_cyc[0], 64'd64);
        check_val("d_nstart", st_n, 64'd4);
        for (int k = 0; k < 4; k++) begin
            check_val($sformatf("d_v%0d", k), {st_v[k], st_u[k]}, 64'd0);
        end

`ifdef NEURON_SCHED_REFRACT_EN
        // ---- refractory: idx 2 fires in step 1, skipped in steps 2 and 3 ----
        reset_assert();
        ev_ready   = 1'b1;
        spike_mask = 4'b0100;
        reset_release();
        watch_sweep(200);
        check_val("e1_nstart", st_n, 64'd4);
        spike_mask = 4'b0000;
        for (int s = 2; s <= 4; s++) begin
            watch_sweep(200);
            hits  = 0;
            hit_v = '0;
            for (int k = 0; k < st_n; k++) begin
                if (st_idx[k] == 2'd2) begin
                    hits++;
                    hit_v = st_v[k];
                end
            end
            check_val($sformatf("e%0d_idx2_hits", s), hits, (s == 4) ? 64'd1 : 64'd0);
            check_val($sformatf("e%0d_nstart", s), st_n, (s == 4) ? 64'd4 : 64'd3);
            if (s == 4) begin
                check_val("e4_idx2_v", hit_v, 64'd1);
                check_val("e4_idx0_v", st_v[0], 64'd3);
            end
        end
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
